// File: rtl/imm_packer.sv
// RISC-V immediate packer: scatters a signed immediate into instruction bits [31:7]
// for I/S/B/J formats, flags range/alignment errors, and queues results in a 2-entry FIFO.
module imm_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      imm_in,
  input  logic [1:0]       ImmSrc,
  input  logic [24:0]      base_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_field,
  output logic             err_range,
  output logic             err_align,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [24:0] pack_field(input logic [31:0] imm,
                                             input logic [1:0]  src,
                                             input logic [24:0] base);
    logic [31:0] instr;
    instr = {base, 7'b0};
    case (src)
      IMM_I: instr[31:20] = imm[11:0];
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
      end
      default: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
      end
    endcase
    return instr[31:7];
  endfunction

  // Sign-extension holds only if every bit above the top encoded bit matches it.
  function automatic logic range_err(input logic [31:0] imm, input logic [1:0] src);
    logic ok;
    case (src)
      IMM_I, IMM_S: ok = (imm[31:11] == '0) || (imm[31:11] == '1);
      IMM_B:        ok = (imm[31:12] == '0) || (imm[31:12] == '1);
      default:      ok = (imm[31:20] == '0) || (imm[31:20] == '1);
    endcase
    return !ok;
  endfunction

  function automatic logic align_err(input logic [31:0] imm, input logic [1:0] src);
    return ((src == IMM_B) || (src == IMM_J)) && imm[0];
  endfunction

  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [24:0]      field_q [2];
  logic [24:0]      field_d [2];
  logic             rng_q   [2];
  logic             rng_d   [2];
  logic             aln_q   [2];
  logic             aln_d   [2];
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic        push, pop;
  logic [24:0] enc_field;
  logic        enc_rng, enc_aln;

  assign enc_field = pack_field(imm_in, ImmSrc, base_in);
  assign enc_rng   = range_err(imm_in, ImmSrc);
  assign enc_aln   = align_err(imm_in, ImmSrc);

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    field_d     = field_q;
    rng_d       = rng_q;
    aln_d       = aln_q;
    err_count_d = err_count_q;
    if (push) begin
      field_d[tail_q] = enc_field;
      rng_d[tail_q]   = enc_rng;
      aln_d[tail_q]   = enc_aln;
      tail_d          = ~tail_q;
      if ((enc_rng || enc_aln) && (err_count_q != {CNT_W{1'b1}}))
        err_count_d = err_count_q + 1'b1;
    end
    if (pop)
      head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_count_q <= err_count_d;
    end
  end

  // Payload storage carries no reset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    field_q <= field_d;
    rng_q   <= rng_d;
    aln_q   <= aln_d;
  end

  assign out_field = out_valid ? field_q[head_q] : 25'd0;
  assign err_range = out_valid && rng_q[head_q];
  assign err_align = out_valid && aln_q[head_q];
  assign err_count = err_count_q;

endmodule
